// File: rtl/posit_decode_pipe.sv
// Two-stage pipelined posit decoder: sign, combined scale, aligned fraction and special flags,
// with a valid/ready handshake and full backpressure in front of the posit arithmetic core.
module posit_decode_pipe #(
    parameter int N  = 16,
    parameter int ES = 1,
    localparam int FW = N - ES - 3,
    localparam int SW = $clog2(N) + ES + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [N-1:0]         in_posit_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic                 out_sign_o,
    output logic signed [SW-1:0] out_scale_o,
    output logic [FW-1:0]        out_frac_o,
    output logic                 out_zero_o,
    output logic                 out_nar_o
);

    localparam int MW = $clog2(N);

    // Leading-zero count over the N-1 magnitude bits; an all-zero word counts as N-1.
    function automatic logic [MW-1:0] lzd(input logic [N-2:0] x);
        logic [MW-1:0] cnt;
        cnt = MW'(N - 1);
        for (int i = 0; i < N - 1; i++) begin
            if (x[i]) cnt = MW'(N - 2 - i);
        end
        return cnt;
    endfunction

    logic          s1Valid_q, s1Valid_d;
    logic          s1Sign_q, s1Sign_d;
    logic          s1Regime_q, s1Regime_d;
    logic [MW-1:0] s1Run_q, s1Run_d;
    logic [N-4:0]  s1Rem_q, s1Rem_d;
    logic          s1Zero_q, s1Zero_d;
    logic          s1Nar_q, s1Nar_d;

    logic                 outValid_q, outValid_d;
    logic                 outSign_q, outSign_d;
    logic signed [SW-1:0] outScale_q, outScale_d;
    logic [FW-1:0]        outFrac_q, outFrac_d;
    logic                 outZero_q, outZero_d;
    logic                 outNar_q, outNar_d;

    logic s2CanTake;
    logic inFire;

    logic [N-2:0] s1Abs;
    logic [N-2:0] runBits;

    logic signed [SW-1:0] runExt;
    logic signed [SW-1:0] kVal;
    logic signed [SW-1:0] expVal;
    logic [N-4:0]         tail;

    always_comb begin
        s2CanTake  = !outValid_q || out_ready_i;
        in_ready_o = !s1Valid_q || s2CanTake;
        inFire     = in_valid_i && in_ready_o;
        s1Valid_d  = inFire ? 1'b1 : (s2CanTake ? 1'b0 : s1Valid_q);
        outValid_d = s2CanTake ? s1Valid_q : outValid_q;
    end

    // Bit N-3 of the magnitude is always run or terminator, so only bits below it are kept.
    always_comb begin
        s1Sign_d   = in_posit_i[N-1];
        s1Abs      = s1Sign_d ? (~in_posit_i[N-2:0] + (N-1)'(1)) : in_posit_i[N-2:0];
        s1Regime_d = s1Abs[N-2];
        runBits    = s1Regime_d ? ~s1Abs : s1Abs;
        s1Run_d    = lzd(runBits);
        s1Rem_d    = s1Abs[N-4:0];
        s1Zero_d   = (in_posit_i == '0);
        s1Nar_d    = (in_posit_i == {1'b1, {(N-1){1'b0}}});
    end

    // Shifting by run-1 drops the rest of the run and the terminator, leaving {exponent, fraction}.
    always_comb begin
        runExt     = SW'(s1Run_q);
        kVal       = s1Regime_q ? (runExt - SW'(1)) : (-runExt);
        tail       = s1Rem_q << (s1Run_q - MW'(1));
        expVal     = SW'(tail >> FW);
        outSign_d  = s1Sign_q;
        outScale_d = (kVal <<< ES) + expVal;
        outFrac_d  = tail[FW-1:0];
        outZero_d  = s1Zero_q;
        outNar_d   = s1Nar_q;
        if (s1Zero_q || s1Nar_q) begin
            outSign_d  = 1'b0;
            outScale_d = '0;
            outFrac_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1Valid_q  <= 1'b0;
            s1Sign_q   <= 1'b0;
            s1Regime_q <= 1'b0;
            s1Run_q    <= '0;
            s1Rem_q    <= '0;
            s1Zero_q   <= 1'b0;
            s1Nar_q    <= 1'b0;
            outValid_q <= 1'b0;
            outSign_q  <= 1'b0;
            outScale_q <= '0;
            outFrac_q  <= '0;
            outZero_q  <= 1'b0;
            outNar_q   <= 1'b0;
        end else begin
            s1Valid_q  <= s1Valid_d;
            outValid_q <= outValid_d;
            if (inFire) begin
                s1Sign_q   <= s1Sign_d;
                s1Regime_q <= s1Regime_d;
                s1Run_q    <= s1Run_d;
                s1Rem_q    <= s1Rem_d;
                s1Zero_q   <= s1Zero_d;
                s1Nar_q    <= s1Nar_d;
            end
            if (s2CanTake && s1Valid_q) begin
                outSign_q  <= outSign_d;
                outScale_q <= outScale_d;
                outFrac_q  <= outFrac_d;
                outZero_q  <= outZero_d;
                outNar_q   <= outNar_d;
            end
        end
    end

    assign out_valid_o = outValid_q;
    assign out_sign_o  = outSign_q;
    assign out_scale_o = outScale_q;
    assign out_frac_o  = outFrac_q;
    assign out_zero_o  = outZero_q;
    assign out_nar_o   = outNar_q;

endmodule

// File: tb/tb_posit_decode_pipe.sv
// Testbench for posit_decode_pipe (N=16, ES=1): known-value table, stall, streaming,
// reset and randomized traffic against a bit-scanning posit reference decoder.
module tb_posit_decode_pipe;

    localparam int N  = 16;
    localparam int ES = 1;
    localparam int FW = N - ES - 3;
    localparam int SW = $clog2(N) + ES + 1;

    typedef struct packed {
        logic                 sign;
        logic signed [SW-1:0] scale;
        logic [FW-1:0]        frac;
        logic                 zero;
        logic                 nar;
    } decT;

    typedef struct {
        logic [N-1:0] p;
        decT          exp;
    } vecT;

    logic                 clk;
    logic                 rst_n;
    logic                 in_valid;
    logic                 in_ready;
    logic [N-1:0]         in_posit;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_sign;
    logic signed [SW-1:0] out_scale;
    logic [FW-1:0]        out_frac;
    logic                 out_zero;
    logic                 out_nar;

    int  testsRun;
    int  testsFailed;
    decT expQ[$];
    vecT vecs[$];
    logic lastOutValid;
    logic lastInReady;

    posit_decode_pipe #(.N(N), .ES(ES)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_posit_i  (in_posit),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_sign_o  (out_sign),
        .out_scale_o (out_scale),
        .out_frac_o  (out_frac),
        .out_zero_o  (out_zero),
        .out_nar_o   (out_nar)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("[TB] FAIL globalTimeout: simulation still running, expected completion");
        $fatal(1, "[TB] timeout");
    end

    // Reference decoder: walks the magnitude bit by bit as a posit is read by hand.
    function automatic decT refDecode(input logic [N-1:0] p);
        decT d;
        logic [N-1:0] a;
        int pos, m, k, e, f;
        d = '0;
        if (p == 16'h0000) begin
            d.zero = 1'b1;
            return d;
        end
        if (p == 16'h8000) begin
            d.nar = 1'b1;
            return d;
        end
        d.sign = p[N-1];
        a = p[N-1] ? 16'(65536 - int'(p)) : p;
        pos = N - 2;
        m = 0;
        while (pos >= 0 && a[pos] == a[N-2]) begin
            m++;
            pos--;
        end
        k = a[N-2] ? m - 1 : -m;
        pos--;
        e = 0;
        for (int j = 0; j < ES; j++) begin
            e = e * 2 + ((pos >= 0) ? int'(a[pos]) : 0);
            pos--;
        end
        f = 0;
        for (int j = 0; j < FW; j++) begin
            f = f * 2 + ((pos >= 0) ? int'(a[pos]) : 0);
            pos--;
        end
        d.scale = SW'(k * (1 << ES) + e);
        d.frac  = FW'(f);
        return d;
    endfunction

    function automatic void addVec(input logic [N-1:0] p, input logic s, input int sc,
                                   input logic [FW-1:0] fr, input logic z, input logic n);
        vecT v;
        v.p         = p;
        v.exp.sign  = s;
        v.exp.scale = SW'(sc);
        v.exp.frac  = fr;
        v.exp.zero  = z;
        v.exp.nar   = n;
        vecs.push_back(v);
    endfunction

    task automatic checkValue(input string name, input int actual, input int expected);
        testsRun++;
        if (actual != expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic checkOutput(input string name, input decT expd);
        decT act;
        act.sign  = out_sign;
        act.scale = out_scale;
        act.frac  = out_frac;
        act.zero  = out_zero;
        act.nar   = out_nar;
        testsRun++;
        if (act !== expd) begin
            testsFailed++;
            $display("[TB] FAIL %s: got sign=%0b scale=%0d frac=%h zero=%0b nar=%0b, expected sign=%0b scale=%0d frac=%h zero=%0b nar=%0b",
                     name, act.sign, act.scale, act.frac, act.zero, act.nar,
                     expd.sign, expd.scale, expd.frac, expd.zero, expd.nar);
        end
    endtask

    // One clock: drive inputs at the falling edge, then score what the next rising edge will transfer.
    task automatic applyStimulus(input bit rdy, input bit vld, input logic [N-1:0] p,
                                 input decT expd, output bit fired);
        @(negedge clk);
        out_ready = rdy;
        in_valid  = vld;
        in_posit  = p;
        #1;
        fired        = vld && in_ready;
        lastOutValid = out_valid;
        lastInReady  = in_ready;
        if (out_valid) begin
            if (expQ.size() == 0) begin
                testsRun++;
                testsFailed++;
                $display("[TB] FAIL spuriousOutput: got out_valid=1, expected 0 with nothing in flight");
            end else if (rdy) begin
                checkOutput("streamOut", expQ.pop_front());
            end else begin
                checkOutput("holdStable", expQ[0]);
            end
        end
        if (fired) expQ.push_back(expd);
    endtask

    task automatic drain(input string name);
        bit fired;
        for (int c = 0; c < 20 && expQ.size() != 0; c++) begin
            applyStimulus(1'b1, 1'b0, '0, '0, fired);
        end
        checkValue(name, expQ.size(), 0);
    endtask

    initial begin
        bit   fired;
        int   lat, idx, stalls, bubbles;
        logic [31:0] rotWord;
        logic [N-1:0] p;
        logic [N-1:0] bpItems[4];

        testsRun    = 0;
        testsFailed = 0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        in_posit    = '0;

        addVec(16'h4000, 1'b0,   0, 12'h000, 1'b0, 1'b0);
        addVec(16'hC000, 1'b1,   0, 12'h000, 1'b0, 1'b0);
        addVec(16'h5A00, 1'b0,   1, 12'hA00, 1'b0, 1'b0);
        addVec(16'h7FFF, 1'b0,  28, 12'h000, 1'b0, 1'b0);
        addVec(16'h0001, 1'b0, -28, 12'h000, 1'b0, 1'b0);
        addVec(16'h0000, 1'b0,   0, 12'h000, 1'b1, 1'b0);
        addVec(16'h8000, 1'b0,   0, 12'h000, 1'b0, 1'b1);
        addVec(16'h3000, 1'b0,  -1, 12'h000, 1'b0, 1'b0);
        addVec(16'hFFFF, 1'b1, -28, 12'h000, 1'b0, 1'b0);
        addVec(16'h6400, 1'b0,   2, 12'h800, 1'b0, 1'b0);
        addVec(16'h0003, 1'b0, -25, 12'h000, 1'b0, 1'b0);
        addVec(16'h7FFE, 1'b0,  26, 12'h000, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        #1;
        checkValue("resetOutValid", out_valid, 0);
        checkValue("resetInReady", in_ready, 1);
        checkOutput("resetData", '0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] known-value table");
        foreach (vecs[i]) begin
            applyStimulus(1'b1, 1'b1, vecs[i].p, vecs[i].exp, fired);
            checkValue($sformatf("acceptIdle_%h", vecs[i].p), fired, 1);
            lat = 0;
            for (int c = 0; c < 10; c++) begin
                applyStimulus(1'b1, 1'b0, '0, '0, fired);
                lat++;
                if (lastOutValid) break;
            end
            checkValue($sformatf("latency_%h", vecs[i].p), lat, 2);
            checkValue($sformatf("drained_%h", vecs[i].p), expQ.size(), 0);
        end

        $display("[TB] backpressure");
        bpItems[0] = 16'h4000;
        bpItems[1] = 16'h5A00;
        bpItems[2] = 16'h7FFF;
        bpItems[3] = 16'h0001;
        idx = 0;
        for (int c = 0; c < 30 && (idx < 4 || expQ.size() != 0); c++) begin
            p = (idx < 4) ? bpItems[idx] : '0;
            applyStimulus(c >= 4, idx < 4, p, refDecode(p), fired);
            if (fired) idx++;
            if (c == 2 || c == 3) checkValue($sformatf("bpInReadyLow_c%0d", c), lastInReady, 0);
        end
        checkValue("bpAllSent", idx, 4);
        drain("bpDrained");

        $display("[TB] rotating one-zero stream");
        stalls  = 0;
        bubbles = 0;
        for (int c = 0; c < 18; c++) begin
            rotWord = {16'h7FFF, 16'h7FFF} >> c;
            p = (c < 16) ? rotWord[N-1:0] : '0;
            applyStimulus(1'b1, c < 16, p, refDecode(p), fired);
            if (c < 16 && !fired) stalls++;
            if (c >= 2 && !lastOutValid) bubbles++;
        end
        checkValue("rotNoStall", stalls, 0);
        checkValue("rotBackToBack", bubbles, 0);
        drain("rotDrained");

        $display("[TB] reset with items in flight");
        applyStimulus(1'b0, 1'b1, 16'h4000, refDecode(16'h4000), fired);
        applyStimulus(1'b0, 1'b1, 16'h5A00, refDecode(16'h5A00), fired);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checkValue("rstPreHeld", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkValue("rstOutValidNow", out_valid, 0);
        checkValue("rstInReadyNow", in_ready, 1);
        expQ.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            applyStimulus(1'b1, 1'b0, '0, '0, fired);
            checkValue($sformatf("quietAfterReset_c%0d", c), lastOutValid, 0);
        end

        $display("[TB] randomized traffic");
        for (int c = 0; c < 300; c++) begin
            case ($urandom_range(0, 15))
                0:       p = 16'h0000;
                1:       p = 16'h8000;
                2:       p = 16'h7FFF;
                3:       p = 16'h0001;
                default: p = N'($urandom);
            endcase
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, p, refDecode(p), fired);
        end
        drain("randDrained");

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
